arbiter_nx1_rr: RTL

//  N-master to 1-slave bus arbiter between hart bus ports and the shared memory bus.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/arbiter_nx1_rr.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the N-to-1 round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } arb_state_t;

    // Owner index width; a single-bit index is kept even for degenerate sizes.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after last, wrapping.
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int          cand;
        logic [N-1:0] rot;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        rot   = '0;
        // k = N lands back on last itself, so it is considered only as the final choice.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            rot  = req >> cand;
            if (!valid && rot[0]) begin
                valid = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/arbiter_nx1_rr.sv
// N-master to 1-slave bus arbiter: round-robin grant, back-to-back handoff, atomic lock.
module arbiter_nx1_rr
    import bus_arb_pkg::*;
#(
    parameter int  N_MASTERS = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  OP_W      = 7,
    localparam int ID_W      = id_width(N_MASTERS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_MASTERS-1:0]        i_bus_en,
    input  logic [N_MASTERS-1:0]        i_wr_en,
    input  logic [N_MASTERS*DATA_W-1:0] i_wr_data,
    input  logic [N_MASTERS*ADDR_W-1:0] i_addr,
    input  logic [N_MASTERS*4-1:0]      i_byte_en,
    input  logic [N_MASTERS-1:0]        i_atomic,
    input  logic [N_MASTERS*OP_W-1:0]   i_operation,
    output logic [N_MASTERS-1:0]        o_ack,
    output logic [N_MASTERS*DATA_W-1:0] o_rd_data,
    input  logic                        i_ack,
    input  logic [DATA_W-1:0]           i_rd_data,
    output logic                        o_bus_en,
    output logic                        o_wr_en,
    output logic [DATA_W-1:0]           o_wr_data,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [3:0]                  o_byte_en,
    output logic                        o_atomic,
    output logic [OP_W-1:0]             o_operation,
    output logic [ID_W-1:0]             o_id
);

    arb_state_t             state;
    logic [ID_W-1:0]        owner;
    logic [ID_W-1:0]        last;
    logic [N_MASTERS-1:0]   owner_oh;
    logic [N_MASTERS-1:0]   pick_req;
    logic [ID_W-1:0]        pick_last;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_valid;
    logic                   active;

    assign owner_oh = N_MASTERS'(1) << owner;
    // Reset also blanks the outputs so an ack arriving in the reset cycle is never forwarded.
    assign active   = (state != ST_IDLE) && !i_rst;

    // From IDLE pick after last; on handoff pick after the owner, excluding it.
    assign pick_req  = (state == ST_IDLE) ? i_bus_en : (i_bus_en & ~owner_oh);
    assign pick_last = (state == ST_IDLE) ? last : owner;

    rr_pick #(.N(N_MASTERS), .ID_W(ID_W)) u_pick (
        .req   (pick_req),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= ID_W'(N_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT, ST_LOCK: begin
                    if (i_ack) begin
                        last <= owner;
                        if (i_atomic[owner]) begin
                            state <= ST_LOCK;
                        end else if (pick_valid) begin
                            owner <= pick_idx;
                            state <= ST_GRANT;
                        end else if (i_bus_en[owner]) begin
                            state <= ST_GRANT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (state == ST_LOCK && !i_bus_en[owner] && !i_atomic[owner]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_wr_data   = '0;
        o_addr      = '0;
        o_byte_en   = '0;
        o_atomic    = 1'b0;
        o_operation = '0;
        o_id        = '0;
        if (active) begin
            o_bus_en    = i_bus_en[owner];
            o_wr_en     = i_wr_en[owner];
            o_wr_data   = i_wr_data[int'(owner)*DATA_W +: DATA_W];
            o_addr      = i_addr[int'(owner)*ADDR_W +: ADDR_W];
            o_byte_en   = i_byte_en[int'(owner)*4 +: 4];
            o_atomic    = i_atomic[owner];
            o_operation = i_operation[int'(owner)*OP_W +: OP_W];
            o_id        = owner;
        end
    end

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_ret
        logic sel;
        assign sel                            = active && (owner == ID_W'(k));
        assign o_ack[k]                       = sel && i_ack;
        assign o_rd_data[k*DATA_W +: DATA_W]  = sel ? i_rd_data : '0;
    end

endmodule
